// File: rtl/tuner_ctrl_search_phy.sv
// Search controller: sweeps the ring-tune DAC code, issues it to the arbiter and tracks peak committed power.
// Optional TUNER_SEARCH_VALLEY_EN adds minimum-power (valley) tracking outputs.
module tuner_ctrl_search_phy #(
  parameter int unsigned DAC_WIDTH = 8,
  parameter int unsigned ADC_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_search_start,
  input  logic [DAC_WIDTH-1:0] i_search_code_start,
  input  logic [DAC_WIDTH-1:0] i_search_code_end,
  input  logic [DAC_WIDTH-1:0] i_search_code_step,
  output logic                 o_ctrl_active,
  output logic                 o_ctrl_refresh,
  output logic                 o_ctrl_ring_tune_val,
  input  logic                 i_ctrl_ring_tune_rdy,
  output logic [DAC_WIDTH-1:0] o_ctrl_ring_tune,
  input  logic                 i_ctrl_commit_val,
  output logic                 o_ctrl_commit_rdy,
  input  logic [ADC_WIDTH-1:0] i_ctrl_pwr_commit,
  input  logic [DAC_WIDTH-1:0] i_ctrl_ring_tune_commit,
  output logic                 o_search_busy,
  output logic                 o_search_done,
  output logic [ADC_WIDTH-1:0] o_search_peak_pwr,
  output logic [DAC_WIDTH-1:0] o_search_peak_code,
`ifdef TUNER_SEARCH_VALLEY_EN
  output logic [ADC_WIDTH-1:0] o_search_valley_pwr,
  output logic [DAC_WIDTH-1:0] o_search_valley_code,
  output logic                 o_search_err
`else
  output logic                 o_search_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REFRESH = 3'd1,
    S_TUNE    = 3'd2,
    S_COMMIT  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DAC_WIDTH-1:0] r_code;
  logic [DAC_WIDTH-1:0] r_end;
  logic [DAC_WIDTH-1:0] r_step;
  logic [ADC_WIDTH-1:0] r_peak_pwr;
  logic [DAC_WIDTH-1:0] r_peak_code;
  logic                 r_err;
  logic                 r_first;
  logic [DAC_WIDTH:0]   w_next;
  logic                 w_last;
  logic                 w_start_fire;
  logic                 w_commit_fire;

  // Carry out of the code adder means the sweep wrapped past the top code
  assign w_next        = {1'b0, r_code} + {1'b0, r_step};
  assign w_last        = w_next[DAC_WIDTH] || (w_next[DAC_WIDTH-1:0] > r_end);
  assign w_start_fire  = i_search_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_commit_fire = (r_state == S_COMMIT) && i_ctrl_commit_val;

  assign o_ctrl_ring_tune   = r_code;
  assign o_search_peak_pwr  = r_peak_pwr;
  assign o_search_peak_code = r_peak_code;
  assign o_search_err       = r_err;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and state-decoded handshake outputs
  always_comb begin
    w_state_nxt          = r_state;
    o_ctrl_active        = 1'b0;
    o_ctrl_refresh       = 1'b0;
    o_ctrl_ring_tune_val = 1'b0;
    o_ctrl_commit_rdy    = 1'b0;
    o_search_busy        = 1'b0;
    o_search_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_search_start) w_state_nxt = S_REFRESH;
      end
      S_REFRESH: begin
        o_ctrl_active  = 1'b1;
        o_search_busy  = 1'b1;
        o_ctrl_refresh = 1'b1;
        w_state_nxt    = S_TUNE;
      end
      S_TUNE: begin
        o_ctrl_active        = 1'b1;
        o_search_busy        = 1'b1;
        o_ctrl_ring_tune_val = 1'b1;
        if (i_ctrl_ring_tune_rdy) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        o_ctrl_active     = 1'b1;
        o_search_busy     = 1'b1;
        o_ctrl_commit_rdy = 1'b1;
        if (i_ctrl_commit_val) w_state_nxt = w_last ? S_DONE : S_TUNE;
      end
      S_DONE: begin
        o_search_done = 1'b1;
        if (i_search_start) w_state_nxt = S_REFRESH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sweep range, current code and peak tracking
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_code      <= '0;
      r_end       <= '0;
      r_step      <= '0;
      r_peak_pwr  <= '0;
      r_peak_code <= '0;
      r_err       <= 1'b0;
      r_first     <= 1'b0;
    end else begin
      if (w_start_fire) begin
        r_code      <= i_search_code_start;
        r_end       <= i_search_code_end;
        r_step      <= (i_search_code_step == '0) ? DAC_WIDTH'(1) : i_search_code_step;
        r_peak_pwr  <= '0;
        r_peak_code <= '0;
        r_err       <= 1'b0;
        r_first     <= 1'b1;
      end
      if (w_commit_fire) begin
        r_first <= 1'b0;
        if (r_first || (i_ctrl_pwr_commit > r_peak_pwr)) begin
          r_peak_pwr  <= i_ctrl_pwr_commit;
          r_peak_code <= i_ctrl_ring_tune_commit;
        end
        if (i_ctrl_ring_tune_commit != r_code) r_err <= 1'b1;
        if (!w_last) r_code <= w_next[DAC_WIDTH-1:0];
      end
    end
  end

`ifdef TUNER_SEARCH_VALLEY_EN
  logic [ADC_WIDTH-1:0] r_valley_pwr;
  logic [DAC_WIDTH-1:0] r_valley_code;

  assign o_search_valley_pwr  = r_valley_pwr;
  assign o_search_valley_code = r_valley_code;

  // Minimum committed power, earliest code on a tie
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valley_pwr  <= '0;
      r_valley_code <= '0;
    end else if (w_start_fire) begin
      r_valley_pwr  <= '0;
      r_valley_code <= '0;
    end else if (w_commit_fire && (r_first || (i_ctrl_pwr_commit < r_valley_pwr))) begin
      r_valley_pwr  <= i_ctrl_pwr_commit;
      r_valley_code <= i_ctrl_ring_tune_commit;
    end
  end
`endif

endmodule

// File: doc/tuner_ctrl_search_phy.md
# tuner_ctrl_search_phy

Producer-side search controller for the tuner control arbiter protocol. It sweeps the ring tuner DAC code over a programmed range and issues each code on the ring-tune val/rdy channel. It then consumes the synchronized (power, code) commit that the arbiter returns for that code and tracks the peak power and the code that produced it. It sits above the arbiter PHY and drives its `ctrl_active`/`ctrl_refresh`, ring-tune and commit channels for the search channel.

## Interface

One clock; reset is synchronous and active-high (`i_clk`, `i_rst`).

Parameters:
- `DAC_WIDTH`, 8, tuner code width
- `ADC_WIDTH`, 8, detected power width

Ports:
- `i_clk`  in  1  clock
- `i_rst`  in  1  synchronous active-high reset
- `i_search_start`  in  1  start pulse; sampled only in IDLE/DONE
- `i_search_code_start`  in  DAC_WIDTH  first code
- `i_search_code_end`  in  DAC_WIDTH  last code (inclusive bound)
- `i_search_code_step`  in  DAC_WIDTH  code increment; 0 treated as 1
- `o_ctrl_active`  out  1  arbiter/power-detect enable
- `o_ctrl_refresh`  out  1  one-cycle arbiter refresh pulse
- `o_ctrl_ring_tune_val`  out  1  tune code valid
- `i_ctrl_ring_tune_rdy`  in  1  arbiter accepts code
- `o_ctrl_ring_tune`  out  DAC_WIDTH  tune code
- `i_ctrl_commit_val`  in  1  synchronized commit valid
- `o_ctrl_commit_rdy`  out  1  commit accept
- `i_ctrl_pwr_commit`  in  ADC_WIDTH  committed power
- `i_ctrl_ring_tune_commit`  in  DAC_WIDTH  committed code
- `o_search_busy`  out  1  sweep in progress
- `o_search_done`  out  1  level; held from sweep end until next start
- `o_search_peak_pwr`  out  ADC_WIDTH  max committed power
- `o_search_peak_code`  out  DAC_WIDTH  committed code at max
- `o_search_err`  out  1  sticky; commit code != issued code

## Operation

- States: IDLE, REFRESH, TUNE, COMMIT, DONE.
- IDLE/DONE + `i_search_start`: latch start/end/step, set code := start, clear peak registers and err, clear done, go to REFRESH.
- REFRESH: `o_ctrl_refresh`=1 for exactly one cycle, then go to TUNE.
- TUNE: `o_ctrl_ring_tune_val`=1. A tune fire (val&&rdy) moves to COMMIT.
- COMMIT: `o_ctrl_commit_rdy`=1. A commit fire (val&&rdy) does the following:
  - Update peak if this is the first sample or `i_ctrl_pwr_commit` > peak (strict; on a tie the earliest code wins).
  - Peak code is taken from `i_ctrl_ring_tune_commit`, not from the issued code.
  - Set err if `i_ctrl_ring_tune_commit` != `o_ctrl_ring_tune`.
  - Compute next = code + step in DAC_WIDTH+1 bits. If there is a carry or next > end, go to DONE; otherwise code := next and go to TUNE.
- Sample count is floor((end−start)/step)+1. If start > end, exactly one sample is taken (at start).
- `o_ctrl_active` = state ∈ {REFRESH, TUNE, COMMIT}. `o_search_busy` has the same value.
- `i_search_start` while busy is ignored. `i_ctrl_commit_val` outside COMMIT is ignored (rdy=0).
- Reset at any time: state IDLE, and every output is 0. This includes code, peak, err and done.

## Timing

- `o_ctrl_ring_tune_val` and `o_ctrl_commit_rdy` are decoded combinationally from the registered state. They have no combinational path from `i_ctrl_*_rdy/val`.
- `o_ctrl_ring_tune` is registered and held stable from entry to TUNE through the COMMIT fire.
- Minimum of 2 cycles per sample on this side (TUNE fire cycle + COMMIT fire cycle). Backpressure on either channel stalls the FSM indefinitely, with outputs stable.
- Start to first val: start at cycle n, refresh at n+1, val at n+2.
- The peak, err and `o_search_done` updates from a commit fire are visible the next cycle. `o_search_busy` falls in the same cycle that done rises.
- Start and reset in the same cycle: reset wins.

## Configuration

- `TUNER_SEARCH_VALLEY_EN`:
  - Defined: adds outputs `o_search_valley_pwr` [ADC_WIDTH] and `o_search_valley_code` [DAC_WIDTH]. These track the minimum committed power with strict <, earliest on tie, first sample initializes. Both reset to 0 and clear on start.
  - Undefined: the ports and registers are absent. Peak behaviour is identical in both cases.

## Test plan

- Sweep start=0, end=15, step=5; arbiter model commits pwr 10,40,40,7 with code echoed. Required: codes 0,5,10,15 issued; peak_pwr=40, peak_code=5; done=1, err=0. With VALLEY_EN, valley=7 at code 15.
- Wrap: start=250, end=255, step=3. Required: codes 250,253 only (256 carries), then done.
- Step=0, start=7, end=9. Required: codes 7,8,9 issued. Also start=20, end=10. Required: single sample at code 20, then done.
- Backpressure: hold tune rdy low 5 cycles and commit val low 8 cycles. Required: val and code stable throughout; no extra samples; result identical to the no-stall run.
- Arbiter commits code 6 for issued code 5. Required: err=1 and stays 1 through done; peak_code reports 6. A new start clears err.
- Assert reset mid-sweep (in COMMIT), then start again. Required: all outputs 0 the cycle after reset; refresh pulses; sweep restarts at the start code.
